// File: rtl/miriscv_branch_pred_bht_if.sv
// Fetch/execute-side signal bundle for the branch history table predictor.
// The master modport belongs to the pipeline; the slave modport to the predictor.
interface miriscv_branch_pred_bht_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] instr_addr_i;
    logic [XLEN-1:0] instr_rdata_i;
    logic            predicted_flag_o;
    logic [XLEN-1:0] pred_target_o;
    logic            pred_dyn_o;
    logic            upd_valid_i;
    logic [XLEN-1:0] upd_addr_i;
    logic            upd_taken_i;
    logic            flush_i;

    modport master (
        output instr_addr_i, instr_rdata_i, upd_valid_i, upd_addr_i, upd_taken_i, flush_i,
        input  predicted_flag_o, pred_target_o, pred_dyn_o
    );

    modport slave (
        input  instr_addr_i, instr_rdata_i, upd_valid_i, upd_addr_i, upd_taken_i, flush_i,
        output predicted_flag_o, pred_target_o, pred_dyn_o
    );
endinterface

// File: rtl/miriscv_branch_pred_bht.sv
// Direct-mapped BHT of saturating counters with static BTFNT fallback for
// untrained entries; also produces the B-type branch target for fetch redirect.
module miriscv_branch_pred_bht #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 2
) (
    input logic                    clk_i,
    input logic                    arstn_i,
    miriscv_branch_pred_bht_if.slave bus
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam logic [6:0]       OPCODE_BRANCH = 7'b1100011;
    localparam logic [CNT_W-1:0] CNT_WT        = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_WNT       = CNT_WT - CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX       = '1;

    logic [IDX_W-1:0]       w_fetch_idx;
    logic [IDX_W-1:0]       w_upd_idx;
    logic [BHT_ENTRIES-1:0] w_valid;
    logic [CNT_W-1:0]       w_cnt [BHT_ENTRIES];
    logic                   w_is_branch;
    logic                   w_entry_valid;
    logic [CNT_W-1:0]       w_entry_cnt;
    logic [XLEN-1:0]        w_imm;

    assign w_fetch_idx = bus.instr_addr_i[IDX_W+1:2];
    assign w_upd_idx   = bus.upd_addr_i[IDX_W+1:2];

    // Storage is flops so the entry can be read combinationally in the fetch cycle.
    genvar gi;
    generate
        for (gi = 0; gi < BHT_ENTRIES; gi++) begin : g_entry
            logic             r_valid;
            logic [CNT_W-1:0] r_cnt;
            logic             w_hit;

            assign w_hit = bus.upd_valid_i && (w_upd_idx == IDX_W'(gi));

            always_ff @(posedge clk_i) begin
                if (!arstn_i) begin
                    r_valid <= 1'b0;
                end else if (bus.flush_i) begin
                    r_valid <= 1'b0;
                end else if (w_hit) begin
                    r_valid <= 1'b1;
                end
            end

            // Counter is meaningless while invalid, so it needs no reset.
            always_ff @(posedge clk_i) begin
                if (arstn_i && !bus.flush_i && w_hit) begin
                    if (!r_valid) begin
                        r_cnt <= bus.upd_taken_i ? CNT_WT : CNT_WNT;
                    end else if (bus.upd_taken_i && (r_cnt != CNT_MAX)) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else if (!bus.upd_taken_i && (r_cnt != '0)) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
            end

            assign w_valid[gi] = r_valid;
            assign w_cnt[gi]   = r_cnt;
        end
    endgenerate

    assign w_is_branch   = (bus.instr_rdata_i[6:0] == OPCODE_BRANCH);
    assign w_entry_valid = w_valid[w_fetch_idx];
    assign w_entry_cnt   = w_cnt[w_fetch_idx];

    assign w_imm = {{(XLEN-12){bus.instr_rdata_i[31]}}, bus.instr_rdata_i[7],
                    bus.instr_rdata_i[30:25], bus.instr_rdata_i[11:8], 1'b0};
    assign bus.pred_target_o = bus.instr_addr_i + w_imm;

    always_comb begin
        bus.predicted_flag_o = 1'b0;
        bus.pred_dyn_o       = 1'b0;
        if (w_is_branch) begin
            if (w_entry_valid) begin
                bus.predicted_flag_o = w_entry_cnt[CNT_W-1];
                bus.pred_dyn_o       = 1'b1;
            end else begin
                bus.predicted_flag_o = bus.instr_rdata_i[XLEN-1];
            end
        end
    end
endmodule

// File: tb/tb_miriscv_branch_pred_bht.sv
// Self-checking bench: vector table for the directed plan, a CNT_W=1 sequence,
// and a randomized phase against a behavioural BHT model.
module tb_miriscv_branch_pred_bht;
    localparam logic [31:0] BB   = 32'hFE000EE3;
    localparam logic [31:0] BF   = 32'h00000463;
    localparam logic [31:0] ADDI = 32'h00100093;

    logic clk_i = 1'b0;
    logic rstn;
    always #5 clk_i = ~clk_i;

    miriscv_branch_pred_bht_if #(.XLEN(32)) b0 ();
    miriscv_branch_pred_bht_if #(.XLEN(32)) b1 ();

    miriscv_branch_pred_bht #(.XLEN(32), .BHT_ENTRIES(64), .CNT_W(2)) dut (
        .clk_i  (clk_i),
        .arstn_i(rstn),
        .bus    (b0)
    );

    miriscv_branch_pred_bht #(.XLEN(32), .BHT_ENTRIES(4), .CNT_W(1)) dut1 (
        .clk_i  (clk_i),
        .arstn_i(rstn),
        .bus    (b1)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        uv;
        logic [31:0] ua;
        logic        ut;
        logic        fl;
        logic        rn;
        logic        ef;
        logic        ed;
        logic [31:0] et;
    } vec_t;

    typedef struct {
        logic        ef;
        logic        ed;
        logic [31:0] et;
    } exp_t;

    vec_t vecs[$];
    exp_t sb0[$];
    exp_t sb1[$];
    int   checks   = 0;
    int   failures = 0;

    int m_valid [64];
    int m_cnt   [64];

    function automatic vec_t mk(logic [31:0] addr, logic [31:0] instr, logic uv, logic [31:0] ua,
                                logic ut, logic fl, logic rn, logic ef, logic ed, logic [31:0] et);
        vec_t v;
        v.addr = addr; v.instr = instr; v.uv = uv; v.ua = ua; v.ut = ut;
        v.fl = fl; v.rn = rn; v.ef = ef; v.ed = ed; v.et = et;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive0(vec_t v);
        b0.instr_addr_i  = v.addr;
        b0.instr_rdata_i = v.instr;
        b0.upd_valid_i   = v.uv;
        b0.upd_addr_i    = v.ua;
        b0.upd_taken_i   = v.ut;
        b0.flush_i       = v.fl;
        rstn             = v.rn;
    endtask

    task automatic step1(logic uv, logic ut, logic ef, logic ed);
        exp_t e;
        b1.instr_addr_i  = 32'h100;
        b1.instr_rdata_i = BF;
        b1.upd_valid_i   = uv;
        b1.upd_addr_i    = 32'h100;
        b1.upd_taken_i   = ut;
        b1.flush_i       = 1'b0;
        e.ef = ef; e.ed = ed; e.et = 32'h108;
        sb1.push_back(e);
        @(negedge clk_i);
        e = sb1.pop_front();
        check("w1_flag", {31'd0, b1.predicted_flag_o}, {31'd0, e.ef});
        check("w1_dyn", {31'd0, b1.pred_dyn_o}, {31'd0, e.ed});
        $display("cnt1 uv=%0b ut=%0b flag=%0b dyn=%0b", uv, ut, b1.predicted_flag_o, b1.pred_dyn_o);
        @(posedge clk_i); #1;
    endtask

    initial begin
        exp_t e;
        vec_t v;
        logic [12:0] imm13;
        logic [5:0]  idx;
        logic        isb;

        // directed plan, one row per cycle; expectations are pre-edge outputs
        vecs.push_back(mk(32'h100, BB,   0, 0,      0, 0, 1, 1, 0, 32'h0FC));
        vecs.push_back(mk(32'h100, BF,   0, 0,      0, 0, 1, 0, 0, 32'h108));
        vecs.push_back(mk(32'h100, ADDI, 0, 0,      0, 0, 1, 0, 0, 32'h900));
        vecs.push_back(mk(32'h100, BF,   1, 32'h100, 1, 0, 1, 0, 0, 32'h108));
        vecs.push_back(mk(32'h100, BF,   0, 0,      0, 0, 1, 1, 1, 32'h108));
        vecs.push_back(mk(32'h100, ADDI, 0, 0,      0, 0, 1, 0, 0, 32'h900));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(32'h100, BF, 1, 32'h100, 1, 0, 1, 1, 1, 32'h108));
        vecs.push_back(mk(32'h100, BF,   1, 32'h100, 0, 0, 1, 1, 1, 32'h108));
        vecs.push_back(mk(32'h100, BF,   1, 32'h100, 0, 0, 1, 1, 1, 32'h108));
        vecs.push_back(mk(32'h100, BF,   0, 0,      0, 0, 1, 0, 1, 32'h108));
        vecs.push_back(mk(32'h200, BF,   1, 32'h100, 1, 0, 1, 0, 1, 32'h208));
        vecs.push_back(mk(32'h200, BF,   0, 0,      0, 0, 1, 1, 1, 32'h208));
        vecs.push_back(mk(32'h104, BB,   0, 0,      0, 0, 1, 1, 0, 32'h100));
        vecs.push_back(mk(32'h100, BF,   1, 32'h104, 1, 1, 1, 1, 1, 32'h108));
        vecs.push_back(mk(32'h100, BF,   0, 0,      0, 0, 1, 0, 0, 32'h108));
        vecs.push_back(mk(32'h104, BF,   0, 0,      0, 0, 1, 0, 0, 32'h10C));
        vecs.push_back(mk(32'h100, BF,   1, 32'h100, 1, 0, 1, 0, 0, 32'h108));
        vecs.push_back(mk(32'h100, BF,   1, 32'h104, 1, 0, 0, 1, 1, 32'h108));
        vecs.push_back(mk(32'h100, BF,   0, 0,      0, 0, 1, 0, 0, 32'h108));
        vecs.push_back(mk(32'h104, BF,   0, 0,      0, 0, 1, 0, 0, 32'h10C));
        vecs.push_back(mk(32'hFFFFFFFC, BF, 0, 0,   0, 0, 1, 0, 0, 32'h00000004));

        drive0(mk(0, ADDI, 0, 0, 0, 0, 0, 0, 0, 0));
        b1.instr_addr_i = 0; b1.instr_rdata_i = ADDI; b1.upd_valid_i = 0;
        b1.upd_addr_i = 0; b1.upd_taken_i = 0; b1.flush_i = 0;
        repeat (3) @(posedge clk_i);
        #1;

        foreach (vecs[i]) begin
            drive0(vecs[i]);
            e.ef = vecs[i].ef; e.ed = vecs[i].ed; e.et = vecs[i].et;
            sb0.push_back(e);
            @(negedge clk_i);
            e = sb0.pop_front();
            check($sformatf("v%0d_flag", i), {31'd0, b0.predicted_flag_o}, {31'd0, e.ef});
            check($sformatf("v%0d_dyn", i), {31'd0, b0.pred_dyn_o}, {31'd0, e.ed});
            check($sformatf("v%0d_tgt", i), b0.pred_target_o, e.et);
            $display("vec %0d pc=%08h flag=%0b dyn=%0b tgt=%08h", i, vecs[i].addr,
                     b0.predicted_flag_o, b0.pred_dyn_o, b0.pred_target_o);
            @(posedge clk_i); #1;
        end
        drive0(mk(0, ADDI, 0, 0, 0, 0, 1, 0, 0, 0));

        // CNT_W=1 behaves as a last-outcome predictor
        step1(0, 0, 0, 0);
        step1(1, 1, 0, 0);
        step1(0, 0, 1, 1);
        step1(1, 0, 1, 1);
        step1(0, 0, 0, 1);
        step1(1, 1, 0, 1);
        step1(0, 0, 1, 1);
        step1(1, 1, 1, 1);
        step1(0, 0, 1, 1);

        // randomized phase; table is fully invalid after the last vector
        for (int k = 0; k < 64; k++) begin m_valid[k] = 0; m_cnt[k] = 0; end
        for (int n = 0; n < 300; n++) begin
            v.addr  = ($urandom & 32'hFFFF_FFC0) | ($urandom_range(0, 15) << 2);
            v.instr = $urandom;
            if ($urandom_range(0, 3) != 0) v.instr[6:0] = 7'h63;
            v.uv = ($urandom_range(0, 2) != 0);
            v.ua = $urandom_range(0, 15) << 2;
            v.ut = $urandom_range(0, 1);
            v.fl = ($urandom_range(0, 29) == 0);
            v.rn = 1'b1;
            isb   = (v.instr[6:0] == 7'h63);
            imm13 = {v.instr[31], v.instr[7], v.instr[30:25], v.instr[11:8], 1'b0};
            idx   = v.addr[7:2];
            e.et  = v.addr + {{19{imm13[12]}}, imm13};
            e.ed  = isb && (m_valid[idx] != 0);
            e.ef  = !isb ? 1'b0 : (m_valid[idx] != 0) ? (m_cnt[idx] >= 2) : v.instr[31];
            drive0(v);
            sb0.push_back(e);
            @(negedge clk_i);
            e = sb0.pop_front();
            check($sformatf("r%0d_flag", n), {31'd0, b0.predicted_flag_o}, {31'd0, e.ef});
            check($sformatf("r%0d_dyn", n), {31'd0, b0.pred_dyn_o}, {31'd0, e.ed});
            check($sformatf("r%0d_tgt", n), b0.pred_target_o, e.et);
            $display("rnd %0d pc=%08h flag=%0b dyn=%0b tgt=%08h", n, v.addr,
                     b0.predicted_flag_o, b0.pred_dyn_o, b0.pred_target_o);
            if (v.fl) begin
                for (int k = 0; k < 64; k++) m_valid[k] = 0;
            end else if (v.uv) begin
                idx = v.ua[7:2];
                if (m_valid[idx] == 0) begin
                    m_valid[idx] = 1;
                    m_cnt[idx]   = v.ut ? 2 : 1;
                end else if (v.ut) begin
                    if (m_cnt[idx] < 3) m_cnt[idx]++;
                end else begin
                    if (m_cnt[idx] > 0) m_cnt[idx]--;
                end
            end
            @(posedge clk_i); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/miriscv_branch_pred_bht.md
Name: miriscv_branch_pred_bht

Overview:
Dynamic conditional-branch predictor for the miriscv fetch stage. It is the parametrised successor to the static backward-taken/forward-not-taken (BTFNT) predictor. A direct-mapped branch history table (BHT) of saturating counters is indexed by fetch PC and trained by resolved branches from execute. Entries that have never been trained fall back to the static BTFNT rule. The block also supplies the predicted branch target so fetch can redirect.

Parameters:
XLEN, 32, data/address width (from miriscv_pkg).
BHT_ENTRIES, 64, number of table entries; power of 2, at least 2.
CNT_W, 2, saturating counter width; at least 1.
IDX_W, $clog2(BHT_ENTRIES), derived localparam; not overridable.

Ports:
clk_i  in  1  core clock.
arstn_i  in  1  reset, synchronous, active-low.
instr_addr_i  in  XLEN  PC of the instruction in fetch.
instr_rdata_i  in  XLEN  fetched instruction word.
predicted_flag_o  out  1  1 = fetch should redirect to pred_target_o.
pred_target_o  out  XLEN  instr_addr_i + B-type immediate.
pred_dyn_o  out  1  1 = prediction came from a trained entry; 0 = static fallback.
upd_valid_i  in  1  resolved conditional branch this cycle.
upd_addr_i  in  XLEN  PC of the resolved branch.
upd_taken_i  in  1  actual outcome of the resolved branch.
flush_i  in  1  invalidate the whole table (fence.i, context switch).

Behaviour:
- Clock and reset: single clock. All state updates on rising clk_i.
- Reset: arstn_i low at an edge clears every valid bit. Counter contents are don't-care once valid is clear.
- Index: fetch uses instr_addr_i[IDX_W+1:2]; update uses upd_addr_i[IDX_W+1:2]. There are no tags, so aliasing is permitted.
- is_branch: instr_rdata_i[6:0] == OPCODE_BRANCH.
- Prediction (combinational from table flops, same cycle):
  - not is_branch: predicted_flag_o=0, pred_dyn_o=0.
  - is_branch and entry invalid: predicted_flag_o = instr_rdata_i[XLEN-1] (BTFNT), pred_dyn_o=0.
  - is_branch and entry valid: predicted_flag_o = counter MSB, pred_dyn_o=1.
- pred_target_o: instr_addr_i + sign-extended {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}, modulo 2^XLEN (wrap, no carry out). Driven for every instruction word; meaningful only when is_branch.
- Outputs directly after reset: pred_dyn_o=0. predicted_flag_o equals the static BTFNT result. pred_target_o is as computed.
- Update (registered, visible the cycle after upd_valid_i):
  - Entry invalid: set valid. Load counter with 2^(CNT_W-1) if taken (weakly taken), else 2^(CNT_W-1)-1 (weakly not-taken).
  - Entry valid: taken increments the counter, saturating at 2^CNT_W-1. Not taken decrements it, saturating at 0.
- Simultaneous fetch read and update of the same index: the prediction uses the pre-update value. There is no bypass.
- flush_i: clears all valid bits at the edge. If flush_i and upd_valid_i are both high, flush wins and the updated entry is also left invalid.
- Priority: arstn_i low > flush_i > upd_valid_i.
- Reset asserted mid-operation: the table is fully invalidated at that edge. A pending update is dropped.
- CNT_W=1: weakly-taken init is 1 and weakly-not-taken init is 0, i.e. a last-outcome predictor.
- No X on outputs when inputs are known. Table storage is flops, not RAM, so it remains readable in the same cycle.

Test Plan:
1. After reset, PC 0x100 with BEQ instr 0xFE000EE3 (offset -4) -> predicted_flag_o=1, pred_dyn_o=0, pred_target_o=0x0FC. Forward BEQ 0x00000463 (offset +8) -> predicted_flag_o=0, pred_target_o=0x108.
2. Non-branch ADDI 0x00100093 at any PC -> predicted_flag_o=0, pred_dyn_o=0, in both trained and untrained state.
3. Training, CNT_W=2: one taken update at 0x100 -> next cycle, forward branch at 0x100 gives predicted_flag_o=1, pred_dyn_o=1. Add 4 more taken, then 1 not-taken -> still 1. One more not-taken -> 0.
4. Same-cycle hazard: entry counter=2, upd_valid_i not-taken at 0x100 while fetching a branch at 0x100 -> this cycle predicted_flag_o=1; next cycle 0.
5. Aliasing with BHT_ENTRIES=64: train 0x100 taken, then fetch a forward branch at 0x200 -> predicted_flag_o=1, pred_dyn_o=1.
6. Flush and reset: train 0x100, then pulse flush_i together with upd_valid_i at 0x104 -> both entries invalid, pred_dyn_o=0. Repeat the same check with arstn_i low for one cycle.
